// File: rtl/s2p_pkg.sv
// Shared definitions for the serial link: FSM state type and counter sizing.
// The transmit side (parallel_to_serial) takes CNT_W and CNT_MAX from here as well.
package s2p_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = $clog2(DATA_W_DEF);
    localparam int CNT_MAX    = DATA_W_DEF - 1;

    // Bit-counter width for a given word width; clamped so a bad DATA_W still elaborates to the error.
    function automatic int calc_cnt_w(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/s2p_out_buf.sv
// Output word register with valid/ready, used by serial_to_parallel when
// S2P_DOUBLE_BUFFER_EN is defined so that collection can overlap a waiting word.
module s2p_out_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              p_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_q, out_d;

    // A load on the same edge as a consume wins: the flag stays set with the new word.
    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (load_i) begin
            out_vld_d = 1'b1;
            out_d     = data_i;
        end else if (p_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign valid_o = out_vld_q;
    assign data_o  = out_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles DATA_W-bit words LSB first from a 1-bit stream.
// Optional feature macro: S2P_DOUBLE_BUFFER_EN (separate output register, no serial bubble).
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    input  logic              s_data_i,
    output logic              s_ready_o,
    output logic              p_valid_o,
    output logic [DATA_W-1:0] p_data_o,
    input  logic              p_ready_i
);

    localparam int            CW       = calc_cnt_w(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    if (DATA_W < 2) begin : g_bad_width
        $error("serial_to_parallel: DATA_W must be >= 2");
    end

    // Both ports: a transfer happens on a rising edge where valid && ready; a
    // producer holds valid and data until that edge, and a consumer may change
    // ready freely.
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_nxt;
    logic              last_bit;
    logic              bit_acc;

`ifdef S2P_DOUBLE_BUFFER_EN
    logic              out_vld;
    logic [DATA_W-1:0] out_data;

    // Stall only the final bit of a word, and only while the previous word is still unclaimed.
    assign s_ready_o = !(last_bit && out_vld && !p_ready_i);

    s2p_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load_i    (bit_acc && last_bit),
        .data_i    (shift_nxt),
        .p_ready_i (p_ready_i),
        .valid_o   (out_vld),
        .data_o    (out_data)
    );

    assign p_valid_o = out_vld;
    assign p_data_o  = out_data;
`else
    state_t state_q, state_d;
    logic   s_ready_q, s_ready_d;
    logic   p_valid_q, p_valid_d;

    assign s_ready_o = s_ready_q;
    assign p_valid_o = p_valid_q;
    assign p_data_o  = shift_q;
`endif

    always_comb begin
        shift_nxt = {s_data_i, shift_q[DATA_W-1:1]};
        last_bit  = (cnt_q == CNT_LAST);
        bit_acc   = s_valid_i && s_ready_o;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        if (bit_acc) begin
            shift_d = shift_nxt;
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
`ifndef S2P_DOUBLE_BUFFER_EN
        state_d   = state_q;
        s_ready_d = s_ready_q;
        p_valid_d = p_valid_q;
        case (state_q)
            ST_COLLECT: begin
                if (bit_acc && last_bit) begin
                    state_d   = ST_HOLD;
                    s_ready_d = 1'b0;
                    p_valid_d = 1'b1;
                end
            end
            // shift_q is frozen here because s_ready_o is low, so p_data_o holds.
            ST_HOLD: begin
                if (p_ready_i) begin
                    state_d   = ST_COLLECT;
                    s_ready_d = 1'b1;
                    p_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_COLLECT;
                s_ready_d = 1'b1;
                p_valid_d = 1'b0;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            shift_q   <= '0;
`ifndef S2P_DOUBLE_BUFFER_EN
            state_q   <= ST_COLLECT;
            s_ready_q <= 1'b1;
            p_valid_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
`ifndef S2P_DOUBLE_BUFFER_EN
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            p_valid_q <= p_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: words are serialised LSB first by the driver,
// queued as expected results, and checked by an independent output monitor.
module tb_serial_to_parallel;

    localparam int DATA_W = 16;
    localparam int TMO    = 200;

    logic              clk;
    logic              reset;
    logic              s_valid_i;
    logic              s_data_i;
    logic              s_ready_o;
    logic              p_valid_o;
    logic [DATA_W-1:0] p_data_o;
    logic              p_ready_i;

    int                cmp_cnt;
    int                err_cnt;
    logic [DATA_W-1:0] exp_q[$];
    int                ready_mode;   // 0: always ready, 1: random, 2: held low
    logic              mon_en;

    serial_to_parallel #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .p_valid_o (p_valid_o),
        .p_data_o  (p_data_o),
        .p_ready_i (p_ready_i)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: timed out after %0d cycles at %0t", name, TMO, $time);
    endtask

    // ---------------- driver tasks ----------------
    // Presents one bit and returns just after the edge on which it was taken.
    task automatic send_bit(input logic b);
        logic acc;
        int   n;
        s_valid_i = 1'b1;
        s_data_i  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < TMO) begin
            @(negedge clk);
            acc = s_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) timeout_fail("send_bit");
        s_valid_i = 1'b0;
        s_data_i  = $urandom_range(0, 1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input int max_gap);
        for (int i = 0; i < DATA_W; i++) begin
            send_bit(w[i]);
            if (max_gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, max_gap));
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!p_valid_o && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!p_valid_o) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout_fail(name);
            exp_q.delete();
        end
    endtask

    // ---------------- downstream ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       p_ready_i = 1'b1;
            1:       p_ready_i = 1'($urandom_range(0, 1));
            default: p_ready_i = 1'b0;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    logic              hold_pend;
    logic [DATA_W-1:0] hold_data;

    always @(negedge clk) begin
        if (!mon_en || reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(p_valid_o), 32'd1);
                check("hold_data", 32'(p_data_o), 32'(hold_data));
            end
`ifndef S2P_DOUBLE_BUFFER_EN
            check("ready_vs_valid", 32'(s_ready_o), 32'(!p_valid_o));
`endif
            if (p_valid_o && p_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(p_data_o), 32'hFFFF_FFFF);
                end else begin
                    check("word", 32'(p_data_o), 32'(exp_q.pop_front()));
                end
            end
            hold_pend = p_valid_o && !p_ready_i;
            hold_data = p_data_o;
        end
    end

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] w;

    initial begin
        cmp_cnt    = 0;
        err_cnt    = 0;
        ready_mode = 0;
        mon_en     = 1'b0;
        hold_pend  = 1'b0;
        s_valid_i  = 1'b0;
        s_data_i   = 1'b0;
        p_ready_i  = 1'b1;
        reset      = 1'b1;
        #1;
        check("reset_s_ready", 32'(s_ready_o), 32'd1);
        check("reset_p_valid", 32'(p_valid_o), 32'd0);
        check("reset_p_data", 32'(p_data_o), 32'd0);
        idle(3);
        reset = 1'b0;
        idle(2);
        mon_en = 1'b1;

        // Basic word, no gaps, always ready: valid one cycle after bit 15, for one cycle.
        w = 16'hA5C3;
        exp_q.push_back(w);
        for (int i = 0; i < DATA_W - 1; i++) send_bit(w[i]);
        check("basic_valid_before_last", 32'(p_valid_o), 32'd0);
        send_bit(w[DATA_W-1]);
        check("basic_valid_latency", 32'(p_valid_o), 32'd1);
        check("basic_data", 32'(p_data_o), 32'hA5C3);
        idle(1);
        check("basic_valid_one_cycle", 32'(p_valid_o), 32'd0);
        drain("basic_drain");

        // Gaps of 3 idle cycles after bits 0, 7 and 15.
        w = 16'h8001;
        exp_q.push_back(w);
        for (int i = 0; i < DATA_W; i++) begin
            send_bit(w[i]);
            if (i == 0 || i == 7 || i == DATA_W - 1) idle(3);
        end
        drain("gaps_drain");

        // Backpressure: word held stable for 5 cycles.
        ready_mode = 2;
        idle(1);
        w = 16'h1234;
        exp_q.push_back(w);
        send_word(w, 0);
        wait_valid("bp_wait");
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(p_valid_o), 32'd1);
            check("bp_data", 32'(p_data_o), 32'h1234);
`ifndef S2P_DOUBLE_BUFFER_EN
            check("bp_s_ready", 32'(s_ready_o), 32'd0);
`endif
            idle(1);
        end
        ready_mode = 0;
        drain("bp_drain");

        // Reset mid-word: 7 bits of 0xFFFF are discarded.
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("midword_rst_s_ready", 32'(s_ready_o), 32'd1);
        check("midword_rst_p_valid", 32'(p_valid_o), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(1);
        mon_en = 1'b1;
        w = 16'h00F0;
        exp_q.push_back(w);
        send_word(w, 0);
        drain("midword_drain");

        // Reset while a word waits: it is dropped and valid falls at once.
        ready_mode = 2;
        idle(1);
        send_word(16'hBEEF, 0);
        wait_valid("hold_rst_wait");
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("hold_rst_p_valid", 32'(p_valid_o), 32'd0);
        check("hold_rst_p_data", 32'(p_data_o), 32'd0);
        idle(2);
        reset      = 1'b0;
        ready_mode = 0;
        idle(1);
        mon_en = 1'b1;

        // Random words, random gaps, random downstream ready.
        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            w = DATA_W'($urandom);
            exp_q.push_back(w);
            send_word(w, 3);
        end
        ready_mode = 0;
        drain("random_drain");

        // Back-to-back fixed words with ready held high.
        for (int k = 1; k <= 3; k++) begin
            w = DATA_W'(k);
            exp_q.push_back(w);
            send_word(w, 0);
        end
        drain("b2b_drain");

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit at %0t", $time);
        err_cnt++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $fatal(1, "global timeout");
    end

endmodule
